// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the digital-clock timekeeping datapath.
package clock_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t SEC_MAX_BCD = 8'h59;
  localparam bcd2_t MIN_MAX_BCD = 8'h59;
  localparam bcd2_t H24_MAX_BCD = 8'h23;
  localparam bcd2_t H12_MAX_BCD = 8'h12;

  function automatic bcd2_t to_bcd2(input int unsigned v);
    return {4'(v / 32'd10), 4'(v % 32'd10)};
  endfunction

  // A value is usable only if both digits are decimal and it lies inside the field range.
  function automatic logic bcd2_in_range(input bcd2_t v, input bcd2_t lo, input bcd2_t hi);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
  endfunction

  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Two-digit BCD counter with wrap from MAX_BCD to MIN_BCD, synchronous clear and a carry-out.
module bcd_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX_BCD = SEC_MAX_BCD,
  parameter bcd2_t MIN_BCD = 8'h00,
  parameter bcd2_t RST_BCD = MIN_BCD
) (
  input  logic  clk,
  input  logic  n_rst,
  input  logic  inc,
  input  logic  clr,
  output bcd2_t q,
  output logic  carry
);

  bcd2_t q_d, q_q;

  // Next value: clear beats increment; corrupted contents recover to the reset value.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = MIN_BCD;
    end else if (inc) begin
      if (!bcd2_in_range(q_q, MIN_BCD, MAX_BCD)) begin
        q_d = RST_BCD;
      end else if (q_q == MAX_BCD) begin
        q_d = MIN_BCD;
      end else begin
        q_d = bcd2_inc(q_q);
      end
    end else begin
      q_d = q_q;
    end
  end

  // Field register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q_q <= RST_BCD;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc & (q_q == MAX_BCD);

endmodule

// File: rtl/time_counter.sv
// Seconds/minutes/hours BCD timekeeping with single-cycle carry cascade and adjust pulses.
module time_counter
  import clock_pkg::*;
#(
  parameter int HOUR_MOD = 24,
  parameter int SEC_MOD  = 60
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en1hz,
  input  logic       adj_mode,
  input  logic       SECINC,
  input  logic       MININC,
  input  logic       HOURINC,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       hour_tick
);

  localparam bcd2_t SEC_MAX  = (SEC_MOD == 60) ? SEC_MAX_BCD : to_bcd2(SEC_MOD - 1);
  localparam bcd2_t HOUR_MAX = (HOUR_MOD == 12) ? H12_MAX_BCD : H24_MAX_BCD;
  localparam bcd2_t HOUR_MIN = (HOUR_MOD == 12) ? 8'h01 : 8'h00;
  localparam bcd2_t HOUR_RST = (HOUR_MOD == 12) ? 8'h12 : 8'h00;

  logic  sec_inc_s, sec_carry_s;
  logic  min_inc_s, min_carry_s, min_wrap_s;
  logic  hour_inc_s, hour_carry_s;
  logic  hour_tick_d, hour_tick_q;
  bcd2_t sec_s, min_s, hour_s;

  // A clear on the same edge as a 1 Hz step suppresses the step, so no minute carry leaks out.
  assign sec_inc_s  = en1hz & ~adj_mode & ~SECINC;
  assign min_inc_s  = MININC | sec_carry_s;
  // An adjust step on minutes absorbs a simultaneous carry and never ripples into hours.
  assign min_wrap_s = min_carry_s & ~MININC;
  assign hour_inc_s = HOURINC | min_wrap_s;

  bcd_counter #(
    .MAX_BCD (SEC_MAX),
    .MIN_BCD (8'h00),
    .RST_BCD (8'h00)
  ) u_sec (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (sec_inc_s),
    .clr   (SECINC),
    .q     (sec_s),
    .carry (sec_carry_s)
  );

  bcd_counter #(
    .MAX_BCD (MIN_MAX_BCD),
    .MIN_BCD (8'h00),
    .RST_BCD (8'h00)
  ) u_min (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (min_inc_s),
    .clr   (1'b0),
    .q     (min_s),
    .carry (min_carry_s)
  );

  bcd_counter #(
    .MAX_BCD (HOUR_MAX),
    .MIN_BCD (HOUR_MIN),
    .RST_BCD (HOUR_RST)
  ) u_hour (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (hour_inc_s),
    .clr   (1'b0),
    .q     (hour_s),
    .carry (hour_carry_s)
  );

  assign hour_tick_d = min_wrap_s & hour_carry_s;

  // Day-wrap pulse, only from the normal counting cascade.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hour_tick_q <= 1'b0;
    end else begin
      hour_tick_q <= hour_tick_d;
    end
  end

  assign sec_bcd   = sec_s;
  assign min_bcd   = min_s;
  assign hour_bcd  = hour_s;
  assign hour_tick = hour_tick_q;

endmodule
